// File: rtl/capture_sub.sv
// Input-capture channel: synchronises an external event pin, detects the
// selected edge(s) and pushes the live counter value into a small FWFT FIFO.
// Sticky capture/overflow flags feed the interrupt logic.
module capture_sub #(
    parameter int unsigned WIDTH       = 32,
    parameter int unsigned DEPTH       = 4,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                     clk_in,
    input  logic                     reset,
    input  logic                     enable,
    input  logic [1:0]               edge_sel,
    input  logic                     cap_in,
    input  logic [WIDTH-1:0]         counter,
    input  logic                     pop,
    input  logic                     clear,
    output logic [WIDTH-1:0]         cap_value,
    output logic                     cap_valid,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     capture,
    output logic                     overflow
);

    localparam int unsigned AW      = $clog2(DEPTH);
    localparam int unsigned CW      = AW + 1;
    localparam int unsigned ARM_MAX = SYNC_STAGES + 1;
    localparam int unsigned ARMW    = $clog2(ARM_MAX + 1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   prev_q;
    logic [ARMW-1:0]        arm_q, arm_d;
    logic [AW-1:0]          wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]          rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]          count_q, count_d;
    logic                   capture_q, capture_d;
    logic                   overflow_q, overflow_d;
    logic [WIDTH-1:0]       mem_q [DEPTH];

    logic synced;
    logic armed;
    logic rise;
    logic fall;
    logic ev;
    logic not_empty;
    logic pop_eff;
    logic push;
    logic drop;

    // Edge detection on the synchronised pin, gated by arming and enable
    always_comb begin
        sync_d    = {sync_q[SYNC_STAGES-2:0], cap_in};
        synced    = sync_q[SYNC_STAGES-1];
        armed     = (arm_q == ARMW'(ARM_MAX));
        arm_d     = armed ? arm_q : arm_q + ARMW'(1);
        rise      = synced & ~prev_q;
        fall      = ~synced & prev_q;
        ev        = armed & enable & ((edge_sel[0] & rise) | (edge_sel[1] & fall));
    end

    // FIFO bookkeeping and sticky flag next-state; a set wins over clear
    always_comb begin
        not_empty  = (count_q != CW'(0));
        pop_eff    = pop & not_empty;
        push       = ev & ((count_q < CW'(DEPTH)) | pop_eff);
        drop       = ev & ~push;
        wr_ptr_d   = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d   = pop_eff ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d    = count_q + CW'(push) - CW'(pop_eff);
        capture_d  = push | (capture_q & ~clear);
        overflow_d = drop | (overflow_q & ~clear);
    end

    // Control state; reset discards FIFO contents by zeroing pointers/count
    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            sync_q     <= '0;
            prev_q     <= 1'b0;
            arm_q      <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            capture_q  <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            sync_q     <= sync_d;
            prev_q     <= synced;
            arm_q      <= arm_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            capture_q  <= capture_d;
            overflow_q <= overflow_d;
        end
    end

    // FIFO storage; contents are only meaningful behind the pointers
    always_ff @(posedge clk_in) begin
        if (push) begin
            mem_q[wr_ptr_q] <= counter;
        end
    end

    assign cap_valid = not_empty;
    assign cap_value = not_empty ? mem_q[rd_ptr_q] : '0;
    assign count     = count_q;
    assign capture   = capture_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_capture_sub.sv
// Self-checking bench for capture_sub: directed scenarios plus a randomized
// run compared against a queue-based reference model.
module tb_capture_sub;

    localparam int unsigned W = 32;
    localparam int unsigned D = 4;
    localparam int unsigned S = 2;

    logic          clk_in;
    logic          reset;
    logic          enable;
    logic [1:0]    edge_sel;
    logic          cap_in;
    logic [W-1:0]  counter;
    logic          pop;
    logic          clear;
    logic [W-1:0]  cap_value;
    logic          cap_valid;
    logic [2:0]    count;
    logic          capture;
    logic          overflow;

    int n_vec;
    int n_err;

    capture_sub #(.WIDTH(W), .DEPTH(D), .SYNC_STAGES(S)) dut (
        .clk_in    (clk_in),
        .reset     (reset),
        .enable    (enable),
        .edge_sel  (edge_sel),
        .cap_in    (cap_in),
        .counter   (counter),
        .pop       (pop),
        .clear     (clear),
        .cap_value (cap_value),
        .cap_valid (cap_valid),
        .count     (count),
        .capture   (capture),
        .overflow  (overflow)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    // Reference model: pin samples per edge since reset release, queue of captures
    bit           hist[$];
    logic [W-1:0] mq[$];
    bit           m_cap;
    bit           m_ovf;
    int           since_rel;

    function automatic bit pin_at(int e);
        if (e >= 1 && e <= hist.size()) return hist[e-1];
        return 1'b0;
    endfunction

    always @(posedge clk_in or negedge reset) begin : model
        bit s_now, s_old, ev, pe, acc;
        if (!reset) begin
            hist.delete();
            mq.delete();
            m_cap = 1'b0;
            m_ovf = 1'b0;
            since_rel = 0;
        end else begin
            since_rel = since_rel + 1;
            // the detector sees the pin as it was S edges ago, against one edge earlier
            s_now = pin_at(since_rel - S);
            s_old = pin_at(since_rel - S - 1);
            ev = (since_rel >= S + 2) && enable &&
                 ((edge_sel[0] && s_now && !s_old) || (edge_sel[1] && !s_now && s_old));
            pe  = pop && (mq.size() > 0);
            acc = ev && ((mq.size() < D) || pe);
            if (pe) void'(mq.pop_front());
            if (acc) mq.push_back(counter);
            m_cap = acc || (m_cap && !clear);
            m_ovf = (ev && !acc) || (m_ovf && !clear);
            hist.push_back(cap_in);
        end
    end

    task automatic clk1();
        @(posedge clk_in);
        @(negedge clk_in);
        counter = counter + 1;
    endtask

    task automatic clkn(int n);
        for (int i = 0; i < n; i++) clk1();
    endtask

    task automatic do_reset(bit level);
        @(negedge clk_in);
        reset  = 1'b0;
        cap_in = level;
        pop    = 1'b0;
        clear  = 1'b0;
        clkn(2);
        reset = 1'b1;
    endtask

    task automatic pulse(int hi, int lo);
        cap_in = 1'b1;
        clkn(hi);
        cap_in = 1'b0;
        clkn(lo);
    endtask

    task automatic test_reset();
        reset = 1'b0; enable = 1'b0; edge_sel = 2'b00; cap_in = 1'b0;
        counter = '0; pop = 1'b0; clear = 1'b0;
        #1;
        n_vec++; if (cap_value !== '0) begin n_err++; $display("FAIL rst_value: got %0d expected 0", cap_value); end
        n_vec++; if (cap_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %0b expected 0", cap_valid); end
        n_vec++; if (count !== 3'd0) begin n_err++; $display("FAIL rst_count: got %0d expected 0", count); end
        n_vec++; if (capture !== 1'b0) begin n_err++; $display("FAIL rst_capture: got %0b expected 0", capture); end
        n_vec++; if (overflow !== 1'b0) begin n_err++; $display("FAIL rst_overflow: got %0b expected 0", overflow); end
    endtask

    task automatic test_arming();
        do_reset(1'b1);
        edge_sel = 2'b01;
        enable   = 1'b1;
        clkn(10);
        n_vec++; if (count !== 3'd0) begin n_err++; $display("FAIL arm_count: got %0d expected 0", count); end
        n_vec++; if (capture !== 1'b0) begin n_err++; $display("FAIL arm_capture: got %0b expected 0", capture); end
    endtask

    task automatic test_latency();
        cap_in = 1'b0;
        clkn(4);
        counter = 32'd100;
        cap_in  = 1'b1;
        clkn(2);
        n_vec++; if (cap_valid !== 1'b0) begin n_err++; $display("FAIL lat_early: got %0b expected 0", cap_valid); end
        clk1();
        n_vec++; if (cap_value !== 32'd102) begin n_err++; $display("FAIL lat_value: got %0d expected 102", cap_value); end
        n_vec++; if (cap_valid !== 1'b1) begin n_err++; $display("FAIL lat_valid: got %0b expected 1", cap_valid); end
        n_vec++; if (count !== 3'd1) begin n_err++; $display("FAIL lat_count: got %0d expected 1", count); end
        n_vec++; if (capture !== 1'b1) begin n_err++; $display("FAIL lat_capture: got %0b expected 1", capture); end
    endtask

    task automatic test_both_edges();
        logic [W-1:0] a;
        logic [W-1:0] b;
        pop = 1'b1; clk1(); pop = 1'b0;
        cap_in = 1'b0;
        clkn(3);
        edge_sel = 2'b11;
        pulse(5, 6);
        n_vec++; if (count !== 3'd2) begin n_err++; $display("FAIL both_count: got %0d expected 2", count); end
        a = cap_value;
        pop = 1'b1; clk1(); pop = 1'b0;
        b = cap_value;
        n_vec++; if (b - a !== 32'd5) begin n_err++; $display("FAIL both_delta: got %0d expected 5", b - a); end
        pop = 1'b1; clk1(); pop = 1'b0;
        n_vec++; if (count !== 3'd0) begin n_err++; $display("FAIL drain_count: got %0d expected 0", count); end
        n_vec++; if (cap_valid !== 1'b0) begin n_err++; $display("FAIL drain_valid: got %0b expected 0", cap_valid); end
        n_vec++; if (cap_value !== '0) begin n_err++; $display("FAIL drain_value: got %0d expected 0", cap_value); end
        pop = 1'b1; clk1(); pop = 1'b0;
        n_vec++; if (count !== 3'd0) begin n_err++; $display("FAIL empty_pop: got %0d expected 0", count); end
        n_vec++; if (cap_valid !== 1'b0) begin n_err++; $display("FAIL empty_pop_valid: got %0b expected 0", cap_valid); end
    endtask

    task automatic test_overflow();
        logic [W-1:0] first_exp;
        logic [W-1:0] sec_exp;
        edge_sel = 2'b01;
        first_exp = '0;
        sec_exp   = '0;
        for (int i = 0; i < 5; i++) begin
            if (i == 0) first_exp = counter + 32'd2;
            if (i == 1) sec_exp   = counter + 32'd2;
            pulse(2, 2);
        end
        clkn(2);
        n_vec++; if (count !== 3'd4) begin n_err++; $display("FAIL ovf_count: got %0d expected 4", count); end
        n_vec++; if (overflow !== 1'b1) begin n_err++; $display("FAIL ovf_flag: got %0b expected 1", overflow); end
        n_vec++; if (cap_value !== first_exp) begin n_err++; $display("FAIL ovf_head: got %0d expected %0d", cap_value, first_exp); end
        clear = 1'b1; clk1(); clear = 1'b0;
        n_vec++; if (overflow !== 1'b0) begin n_err++; $display("FAIL ovf_clear: got %0b expected 0", overflow); end
        cap_in = 1'b1;
        clkn(2);
        pop = 1'b1; clk1(); pop = 1'b0;
        cap_in = 1'b0;
        clkn(2);
        n_vec++; if (count !== 3'd4) begin n_err++; $display("FAIL full_pushpop_count: got %0d expected 4", count); end
        n_vec++; if (overflow !== 1'b0) begin n_err++; $display("FAIL full_pushpop_ovf: got %0b expected 0", overflow); end
        n_vec++; if (cap_value !== sec_exp) begin n_err++; $display("FAIL full_pushpop_head: got %0d expected %0d", cap_value, sec_exp); end
    endtask

    task automatic test_clear_priority();
        pop = 1'b1; clkn(2); pop = 1'b0;
        clear = 1'b1; clk1(); clear = 1'b0;
        n_vec++; if (capture !== 1'b0) begin n_err++; $display("FAIL clr_pre: got %0b expected 0", capture); end
        cap_in = 1'b1;
        clkn(2);
        clear = 1'b1; clk1(); clear = 1'b0;
        n_vec++; if (capture !== 1'b1) begin n_err++; $display("FAIL clr_prio: got %0b expected 1", capture); end
        n_vec++; if (count !== 3'd3) begin n_err++; $display("FAIL clr_prio_count: got %0d expected 3", count); end
        cap_in = 1'b0;
        clkn(3);
        pulse(2, 2);
        pulse(2, 3);
        n_vec++; if (overflow !== 1'b1) begin n_err++; $display("FAIL clr_ovf_set: got %0b expected 1", overflow); end
        clear = 1'b1; clk1(); clear = 1'b0;
        n_vec++; if (capture !== 1'b0) begin n_err++; $display("FAIL clr_cap: got %0b expected 0", capture); end
        n_vec++; if (overflow !== 1'b0) begin n_err++; $display("FAIL clr_ovf: got %0b expected 0", overflow); end
        n_vec++; if (count !== 3'd4) begin n_err++; $display("FAIL clr_keep: got %0d expected 4", count); end
    endtask

    task automatic test_enable_and_reset();
        do_reset(1'b0);
        clkn(5);
        enable   = 1'b0;
        edge_sel = 2'b11;
        pulse(3, 4);
        n_vec++; if (count !== 3'd0) begin n_err++; $display("FAIL en_gate: got %0d expected 0", count); end
        cap_in = 1'b1;
        clkn(4);
        enable = 1'b1;
        clkn(5);
        n_vec++; if (count !== 3'd0) begin n_err++; $display("FAIL en_raise: got %0d expected 0", count); end
        n_vec++; if (capture !== 1'b0) begin n_err++; $display("FAIL en_raise_cap: got %0b expected 0", capture); end
        edge_sel = 2'b01;
        cap_in = 1'b0;
        clkn(4);
        pulse(2, 2);
        pulse(2, 2);
        pulse(2, 3);
        n_vec++; if (count !== 3'd3) begin n_err++; $display("FAIL rst_pre: got %0d expected 3", count); end
        reset = 1'b0;
        #1;
        n_vec++; if (count !== 3'd0) begin n_err++; $display("FAIL midrst_count: got %0d expected 0", count); end
        n_vec++; if (cap_valid !== 1'b0) begin n_err++; $display("FAIL midrst_valid: got %0b expected 0", cap_valid); end
        n_vec++; if (cap_value !== '0) begin n_err++; $display("FAIL midrst_value: got %0d expected 0", cap_value); end
        @(negedge clk_in);
        reset = 1'b1;
    endtask

    task automatic test_random();
        logic [W-1:0] ev_val;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(15) == 0) edge_sel = 2'($urandom_range(3));
            enable = ($urandom_range(9) != 0);
            if ($urandom_range(3) == 0) cap_in = ~cap_in;
            pop    = ($urandom_range(2) == 0);
            clear  = ($urandom_range(9) == 0);
            clk1();
            counter = $urandom();
            ev_val = (mq.size() > 0) ? mq[0] : '0;
            n_vec++; if (count !== 3'(mq.size())) begin n_err++; $display("FAIL rnd_count @%0d: got %0d expected %0d", i, count, mq.size()); end
            n_vec++; if (cap_valid !== (mq.size() > 0)) begin n_err++; $display("FAIL rnd_valid @%0d: got %0b expected %0b", i, cap_valid, mq.size() > 0); end
            n_vec++; if (cap_value !== ev_val) begin n_err++; $display("FAIL rnd_value @%0d: got %0d expected %0d", i, cap_value, ev_val); end
            n_vec++; if (capture !== m_cap) begin n_err++; $display("FAIL rnd_capture @%0d: got %0b expected %0b", i, capture, m_cap); end
            n_vec++; if (overflow !== m_ovf) begin n_err++; $display("FAIL rnd_overflow @%0d: got %0b expected %0b", i, overflow, m_ovf); end
        end
        pop = 1'b0;
        clear = 1'b0;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        test_reset();
        test_arming();
        test_latency();
        test_both_edges();
        test_overflow();
        test_clear_priority();
        test_enable_and_reset();
        enable   = 1'b1;
        edge_sel = 2'b11;
        clkn(4);
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
